lfsr_23_checker: RTL and testbench

//  Serial checker for the 23-bit LFSR pseudo-random streams our uniform generators produce. It

---
 rtl/lfsr_23_pkg.sv | 21 ++
 rtl/lfsr_23_checker_if.sv | 23 ++
 rtl/lfsr_23_checker_sat_counter.sv | 22 ++
 rtl/lfsr_23_checker.sv | 124 ++++++++++++
 tb/tb_lfsr_23_checker.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_23_pkg.sv
// Shared definitions for the 23-bit LFSR generator/checker pair: state encoding and
// the single feedback function both sides use so the polynomial lives in one place.
package lfsr_23_pkg;

    localparam int LFSR_W    = 23;
    localparam int DEF_TAP_A = 23;
    localparam int DEF_TAP_B = 18;

    typedef enum logic {SEED, CHECK} state_t;
    typedef logic [LFSR_W-1:0] lfsr_t;

    // One shift of a Fibonacci LFSR; taps are 1-based, the new bit enters at bit 0.
    function automatic lfsr_t lfsr_23_next(input lfsr_t state, input int tap_a, input int tap_b);
        logic [4:0] ia;
        logic [4:0] ib;
        ia = 5'(tap_a - 1);
        ib = 5'(tap_b - 1);
        return {state[LFSR_W-2:0], state[ia] ^ state[ib]};
    endfunction

endpackage

// File: rtl/lfsr_23_checker_if.sv
// Receive-side bundle of one LFSR checker lane: stream input, count clear and status.
interface lfsr_23_checker_if #(
    parameter int P_CNT_W = 32
);
    logic               din;
    logic               din_valid;
    logic               clr_cnt;
    logic               locked;
    logic               err;
    logic [P_CNT_W-1:0] err_cnt;
    logic [P_CNT_W-1:0] bit_cnt;
    logic               sync_loss;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, err, err_cnt, bit_cnt, sync_loss
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, err, err_cnt, bit_cnt, sync_loss
    );
endinterface

// File: rtl/lfsr_23_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coincident with an increment
// counts that increment so no event is lost across the clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= W'(inc);
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/lfsr_23_checker.sv
// Serial 23-bit LFSR stream checker: self-seeds from received bits, then predicts each
// bit, flags mismatches, counts errors/bits and drops lock on too many errors per window.
module lfsr_23_checker
    import lfsr_23_pkg::*;
#(
    parameter int P_TAP_A       = DEF_TAP_A,
    parameter int P_TAP_B       = DEF_TAP_B,
    parameter int P_CNT_W       = 32,
    parameter int P_WIN         = 1024,
    parameter int P_LOSS_THRESH = 64
) (
    input  logic              clk,
    input  logic              rst,
    lfsr_23_checker_if.slave  bus
);
    localparam int               WIN_W     = $clog2(P_WIN + 1);
    localparam int               ERR_W     = $clog2(P_LOSS_THRESH + 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(P_WIN);
    localparam logic [ERR_W-1:0] ERR_LAST  = ERR_W'(P_LOSS_THRESH);
    localparam logic [4:0]       SEED_LAST = 5'(LFSR_W - 1);

    state_t           state_q, state_d;
    lfsr_t            s_q, s_d, s_pred;
    logic [4:0]       seed_cnt_q, seed_cnt_d;
    logic [WIN_W-1:0] win_bits_q, win_bits_d, win_bits_inc;
    logic [ERR_W-1:0] win_errs_q, win_errs_d, win_errs_inc;
    logic             err_q, err_d;
    logic             sync_loss_q, sync_loss_d;
    logic             check_bit, mismatch;

    // The register always advances on the predicted bit, so a single channel error
    // cannot corrupt later predictions.
    assign s_pred    = lfsr_23_next(s_q, P_TAP_A, P_TAP_B);
    assign check_bit = bus.din_valid && (state_q == CHECK);
    assign mismatch  = check_bit && (bus.din != s_pred[0]);

    assign win_bits_inc = win_bits_q + 1'b1;
    assign win_errs_inc = win_errs_q + ERR_W'(mismatch);

    // NOTE: every variable gets its default before any branch, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        seed_cnt_d  = seed_cnt_q;
        win_bits_d  = win_bits_q;
        win_errs_d  = win_errs_q;
        err_d       = 1'b0;
        sync_loss_d = 1'b0;
        if (bus.din_valid) begin
            unique case (state_q)
                SEED: begin
                    s_d = {s_q[LFSR_W-2:0], bus.din};
                    if (seed_cnt_q == SEED_LAST) begin
                        // An all-zero seed is the LFSR lock-up state; keep seeding instead.
                        seed_cnt_d = '0;
                        if (s_d != '0) begin
                            state_d = CHECK;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
                CHECK: begin
                    s_d   = s_pred;
                    err_d = mismatch;
                    if (win_errs_inc == ERR_LAST) begin
                        state_d     = SEED;
                        sync_loss_d = 1'b1;
                        seed_cnt_d  = '0;
                        win_bits_d  = '0;
                        win_errs_d  = '0;
                    end else if (win_bits_inc == WIN_LAST) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        win_bits_d = win_bits_inc;
                        win_errs_d = win_errs_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            s_q         <= '0;
            seed_cnt_q  <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            err_q       <= 1'b0;
            sync_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            seed_cnt_q  <= seed_cnt_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            err_q       <= err_d;
            sync_loss_q <= sync_loss_d;
        end
    end

    assign bus.locked    = (state_q == CHECK);
    assign bus.err       = err_q;
    assign bus.sync_loss = sync_loss_q;

    sat_counter #(.W(P_CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mismatch),
        .clr (bus.clr_cnt),
        .q   (bus.err_cnt)
    );

    sat_counter #(.W(P_CNT_W)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (check_bit),
        .clr (bus.clr_cnt),
        .q   (bus.bit_cnt)
    );
endmodule

// File: tb/tb_lfsr_23_checker.sv
// Directed bench for lfsr_23_checker: a full-width lane plus a 4-bit-counter lane fed the
// same stream, so counter saturation is reachable in a few dozen errors.
module tb_lfsr_23_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_23_checker_if #(.P_CNT_W(32)) bus ();
    lfsr_23_checker_if #(.P_CNT_W(4))  sbus ();

    assign sbus.din       = bus.din;
    assign sbus.din_valid = bus.din_valid;
    assign sbus.clr_cnt   = bus.clr_cnt;

    lfsr_23_checker #(.P_CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lfsr_23_checker #(.P_CNT_W(4)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int          n_bits, err_pulses, err_at, sl_pulses, sl_at;
    int          lock_rises, lock_at, unlocked;
    logic        prev_locked;
    logic [22:0] gen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent reference generator, x^23 + x^18 + 1, new bit emitted each step.
    function automatic logic next_bit();
        logic b;
        b   = gen[22] ^ gen[17];
        gen = {gen[21:0], b};
        return b;
    endfunction

    task automatic tick(input logic b, input logic v, input logic c);
        bus.din       = b;
        bus.din_valid = v;
        bus.clr_cnt   = c;
        @(posedge clk);
        #1;
        if (v) n_bits++;
        if (bus.err) begin
            err_pulses++;
            err_at = n_bits;
        end
        if (bus.sync_loss) begin
            sl_pulses++;
            sl_at = n_bits;
        end
        if (bus.locked && !prev_locked) begin
            lock_rises++;
            lock_at = n_bits;
        end
        if (!bus.locked && lock_rises > 0) unlocked++;
        prev_locked = bus.locked;
    endtask

    task automatic reset_phase();
        rst           = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b0;
        n_bits      = 0;
        err_pulses  = 0;
        err_at      = -1;
        sl_pulses   = 0;
        sl_at       = -1;
        lock_rises  = 0;
        lock_at     = -1;
        unlocked    = 0;
        prev_locked = 1'b0;
        gen         = 23'd1;
    endtask

    initial begin
        logic b, v, inv;
        int   j;

        // Test 1: clean stream, reset values, lock timing, counts
        reset_phase();
        check("reset_locked",    64'(bus.locked),    0);
        check("reset_err",       64'(bus.err),       0);
        check("reset_sync_loss", 64'(bus.sync_loss), 0);
        check("reset_err_cnt",   64'(bus.err_cnt),   0);
        check("reset_bit_cnt",   64'(bus.bit_cnt),   0);
        for (int k = 1; k <= 1000; k++) tick(next_bit(), 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("t1_lock_at",      64'(lock_at),       23);
        check("t1_lock_rises",   64'(lock_rises),    1);
        check("t1_err_pulses",   64'(err_pulses),    0);
        check("t1_err_cnt",      64'(bus.err_cnt),   0);
        check("t1_bit_cnt",      64'(bus.bit_cnt),   977);
        check("t1_small_bitsat", 64'(sbus.bit_cnt),  15);

        // Test 2: single inverted bit gives exactly one pulse
        reset_phase();
        for (int k = 1; k <= 1000; k++) tick(next_bit() ^ (k == 100), 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("t2_err_pulses", 64'(err_pulses),   1);
        check("t2_err_at",     64'(err_at),       100);
        check("t2_err_cnt",    64'(bus.err_cnt),  1);
        check("t2_unlocked",   64'(unlocked),     0);
        check("t2_bit_cnt",    64'(bus.bit_cnt),  977);

        // Test 3: every 4th checked bit inverted until sync loss, then clean relock
        reset_phase();
        for (int k = 1; k <= 400; k++) begin
            inv = (k > 23) && (k <= 279) && ((k - 23) % 4 == 0);
            tick(next_bit() ^ inv, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0);
        check("t3_sl_pulses",  64'(sl_pulses),    1);
        check("t3_sl_at",      64'(sl_at),        279);
        check("t3_unlocked",   64'(unlocked),     23);
        check("t3_relock_at",  64'(lock_at),      302);
        check("t3_err_pulses", 64'(err_pulses),   64);
        check("t3_err_cnt",    64'(bus.err_cnt),  64);
        check("t3_bit_cnt",    64'(bus.bit_cnt),  354);
        check("t3_locked_end", 64'(bus.locked),   1);

        // Test 4: all-zero input never locks
        reset_phase();
        for (int k = 1; k <= 200; k++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("t4_lock_rises", 64'(lock_rises),  0);
        check("t4_err_pulses", 64'(err_pulses),  0);
        check("t4_err_cnt",    64'(bus.err_cnt), 0);
        check("t4_bit_cnt",    64'(bus.bit_cnt), 0);

        // Test 5: test 1 stream with random valid gaps and garbage on idle cycles
        reset_phase();
        while (n_bits < 1000) begin
            v = ($urandom_range(0, 1) == 1);
            if (v) tick(next_bit(), 1'b1, 1'b0);
            else   tick(($urandom_range(0, 1) == 1), 1'b0, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0);
        check("t5_lock_at",    64'(lock_at),     23);
        check("t5_err_pulses", 64'(err_pulses),  0);
        check("t5_err_cnt",    64'(bus.err_cnt), 0);
        check("t5_bit_cnt",    64'(bus.bit_cnt), 977);

        // Test 6: saturation on the 4-bit lane, clear with error, reset mid-CHECK
        reset_phase();
        for (int k = 1; k <= 150; k++) begin
            inv = ((k >= 30) && (k <= 110) && ((k - 30) % 5 == 0)) || (k == 121) || (k == 150);
            tick(next_bit() ^ inv, 1'b1, (k == 121));
            if (k == 95) begin
                check("t6_small_err_m1", 64'(sbus.err_cnt), 14);
                check("t6_big_err_14",   64'(bus.err_cnt),  14);
            end
            if (k == 110) begin
                check("t6_small_err_sat", 64'(sbus.err_cnt), 15);
                check("t6_big_err_17",    64'(bus.err_cnt),  17);
            end
            if (k == 121) begin
                check("t6_clr_err_cnt",   64'(bus.err_cnt),  1);
                check("t6_clr_bit_cnt",   64'(bus.bit_cnt),  1);
                check("t6_clr_small_err", 64'(sbus.err_cnt), 1);
            end
        end
        check("t6_err_before_rst", 64'(bus.err), 1);
        rst = 1'b1;
        b   = next_bit();
        bus.din       = ~b;
        bus.din_valid = 1'b1;
        bus.clr_cnt   = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_locked",    64'(bus.locked),    0);
        check("t6_rst_err",       64'(bus.err),       0);
        check("t6_rst_sync_loss", 64'(bus.sync_loss), 0);
        check("t6_rst_err_cnt",   64'(bus.err_cnt),   0);
        check("t6_rst_bit_cnt",   64'(bus.bit_cnt),   0);

        // Test 7: errors spread across windows, each window restart keeps lock
        reset_phase();
        for (int k = 1; k <= 1423; k++) begin
            j   = k - 23;
            inv = (j > 0) && (j % 20 == 0);
            tick(next_bit() ^ inv, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0);
        check("t7_sl_pulses", 64'(sl_pulses),    0);
        check("t7_unlocked",  64'(unlocked),     0);
        check("t7_err_cnt",   64'(bus.err_cnt),  70);
        check("t7_bit_cnt",   64'(bus.bit_cnt),  1400);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
